// File: rtl/axis_log_arbiter.sv
// Round-robin arbiter merging NUM_SRC byte-wide AXI-Stream logger sources into one stream.
// Define AXIS_LOG_ARBITER_HEADER_EN to prefix each packet with a {4'hA, source index} header byte.
module axis_log_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int SBITS   = $clog2(NUM_SRC)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable_i,
    input  logic [NUM_SRC-1:0]     s_tvalid,
    output logic [NUM_SRC-1:0]     s_tready,
    input  logic [NUM_SRC-1:0]     s_tlast,
    input  logic [8*NUM_SRC-1:0]   s_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   m_tkeep,
    output logic [7:0]             m_tdata,
    output logic [NUM_SRC-1:0]     grant_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [SBITS-1:0]     r_rr;
    logic [SBITS-1:0]     w_rr_nxt;
    logic [SBITS-1:0]     r_idx;
    logic [SBITS-1:0]     w_idx_nxt;
    logic [NUM_SRC-1:0]   r_grant;
    logic [NUM_SRC-1:0]   w_grant_nxt;
    logic                 r_m_tvalid;
    logic                 r_m_tlast;
    logic [7:0]           r_m_tdata;

    logic                 w_out_free;
    logic                 w_found;
    logic [SBITS-1:0]     w_pick;
    logic                 w_src_valid;
    logic                 w_src_last;
    logic [7:0]           w_src_byte;
    logic                 w_load;
    logic                 w_load_last;
    logic [7:0]           w_load_data;
    logic [NUM_SRC-1:0]   w_tready;

    function automatic logic [SBITS-1:0] wrapIdx(input int v);
        return SBITS'((v >= NUM_SRC) ? (v - NUM_SRC) : v);
    endfunction

    assign w_out_free  = !r_m_tvalid || m_tready;
    assign w_src_valid = s_tvalid[r_idx];
    assign w_src_last  = s_tlast[r_idx];
    assign w_src_byte  = s_tdata[int'(r_idx)*8 +: 8];

    // First requester at or after the round-robin pointer, wrapping past the top index.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!w_found && s_tvalid[wrapIdx(int'(r_rr) + i)]) begin
                w_found = 1'b1;
                w_pick  = wrapIdx(int'(r_rr) + i);
            end
        end
    end

    always_comb begin
        w_tready = '0;
        if (r_state == DATA) begin
            w_tready[r_idx] = w_out_free;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr;
        w_idx_nxt   = r_idx;
        w_grant_nxt = r_grant;
        w_load      = 1'b0;
        w_load_last = 1'b0;
        w_load_data = 8'h00;
        case (r_state)
            IDLE: begin
                if (enable_i && w_found) begin
                    w_idx_nxt   = w_pick;
                    w_grant_nxt = '0;
                    w_grant_nxt[w_pick] = 1'b1;
`ifdef AXIS_LOG_ARBITER_HEADER_EN
                    w_state_nxt = HEADER;
`else
                    w_state_nxt = DATA;
`endif
                end
            end
`ifdef AXIS_LOG_ARBITER_HEADER_EN
            HEADER: begin
                if (w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = {4'hA, 4'(r_idx)};
                    w_state_nxt = DATA;
                end
            end
`endif
            DATA: begin
                if (w_src_valid && w_out_free) begin
                    w_load      = 1'b1;
                    w_load_data = w_src_byte;
                    w_load_last = w_src_last;
                    // Packet ends: release the grant and pass priority to the next source.
                    if (w_src_last) begin
                        w_rr_nxt    = wrapIdx(int'(r_idx) + 1);
                        w_grant_nxt = '0;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rr    <= '0;
            r_idx   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rr    <= w_rr_nxt;
            r_idx   <= w_idx_nxt;
            r_grant <= w_grant_nxt;
        end
    end

    // Output register holds its contents while the downstream stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_m_tdata  <= 8'h00;
        end else if (w_load) begin
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= w_load_last;
            r_m_tdata  <= w_load_data;
        end else if (m_tready) begin
            r_m_tvalid <= 1'b0;
        end
    end

    assign s_tready = w_tready;
    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign m_tdata  = r_m_tdata;
    assign m_tkeep  = r_m_tvalid;
    assign grant_o  = r_grant;
    assign busy_o   = (r_state != IDLE);

endmodule
